// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC register-bus initiator.
// Holds the transfer state encoding and the writable register map.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [7:0] ADDR_TIME   = 8'h00;
    localparam logic [7:0] ADDR_ALARM  = 8'h04;
    localparam logic [7:0] ADDR_ADJUST = 8'h08;

    function automatic logic is_valid_wr_addr(input logic [7:0] addr);
        return (addr == ADDR_TIME) || (addr == ADDR_ALARM) || (addr == ADDR_ADJUST);
    endfunction

endpackage

// File: rtl/rtc_bus_timeout.sv
// ACCESS-phase wait counter: cleared at transfer start, saturating increment,
// expired flag when the count reaches TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES=0).
module rtc_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] SAT  = {CW{1'b1}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment; saturate instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES > 0) && (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_master.sv
// RTC register-bus initiator: one command at a time turned into a SETUP/ACCESS
// transfer, with the result returned on a valid/ready response handshake.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit STRICT_ADDR    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        sel,
    output logic        enable,
    output logic        write,
    output logic [7:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        ready
);

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        sel_q, sel_d;
    logic        enable_q, enable_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        tmo_clr_s;
    logic        tmo_inc_s;
    logic        tmo_expired_s;

    rtc_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmo_clr_s),
        .inc_i    (tmo_inc_s),
        .expired_o(tmo_expired_s)
    );

    // Transfer sequencing; the bus registers double as the command latch.
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_clr_s   = 1'b0;
        tmo_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (STRICT_ADDR && cmd_write && !is_valid_wr_addr(cmd_addr)) begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d   = SETUP;
                        tmo_clr_s = 1'b1;
                        write_d   = cmd_write;
                        addr_d    = cmd_addr;
                        wdata_d   = cmd_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // ready on the final counted cycle still completes successfully.
                if (ready) begin
                    state_d     = RESP;
                    rsp_rdata_d = write_q ? 32'h0000_0000 : rdata;
                    rsp_error_d = 1'b0;
                end else begin
                    tmo_inc_s = 1'b1;
                    if (tmo_expired_s) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'h0000_0000;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_error_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_d       = (state_d == SETUP) || (state_d == ACCESS);
        enable_d    = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        if (!sel_d) begin
            write_d = 1'b0;
            addr_d  = 8'h00;
            wdata_d = 32'h0000_0000;
        end else begin
            write_d = write_d;
        end
    end

    // State and registered output bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign sel       = sel_q;
    assign enable    = enable_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master with a cycle-age reference model and a
// per-cycle output comparison.
module tb_rtc_bus_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        sel;
    logic        enable;
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        ready = 1'b0;

    rtc_bus_master #(.TIMEOUT_CYCLES(TO), .STRICT_ADDR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_after = 0;
    int en_run = 0;
    int acc_total = 0;
    int sel_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave stub: ready rises on the (ready_after+1)-th ACCESS cycle; -1 = never.
    always @(negedge clk) begin
        if (enable) begin
            en_run    <= en_run + 1;
            ready     <= (ready_after >= 0) && (en_run + 1 > ready_after);
            acc_total <= acc_total + 1;
        end else begin
            en_run <= 0;
            ready  <= 1'b0;
        end
        if (sel) sel_total <= sel_total + 1;
    end

    // Reference model: m_age is cycles since a bus command was accepted
    // (0 = SETUP cycle, >=1 = ACCESS cycle number), -1 when no transfer.
    int          m_age = -1;
    bit          m_pend = 1'b0;
    bit          m_wr = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_age = -1; m_pend = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
        end else if (m_pend) begin
            if (rsp_ready) begin
                m_pend = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
            end
        end else if (m_age < 0) begin
            if (cmd_valid) begin
                m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
                if (cmd_write && !(cmd_addr == 8'h00 || cmd_addr == 8'h04 || cmd_addr == 8'h08)) begin
                    m_pend = 1'b1; m_err = 1'b1; m_rdata = 32'h0;
                end else begin
                    m_age = 0;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (ready) begin
            m_pend = 1'b1; m_err = 1'b0; m_rdata = m_wr ? 32'h0 : rdata; m_age = -1;
        end else if (m_age == TO) begin
            m_pend = 1'b1; m_err = 1'b1; m_rdata = 32'h0; m_age = -1;
        end else begin
            m_age = m_age + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit e_sel;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_sel", 32'(sel), 32'd0);
                chk("rst_enable", 32'(enable), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                e_sel = (m_age >= 0);
                chk("m_sel", 32'(sel), 32'(e_sel));
                chk("m_enable", 32'(enable), 32'(m_age >= 1));
                chk("m_write", 32'(write), e_sel ? 32'(m_wr) : 32'd0);
                chk("m_addr", 32'(addr), e_sel ? 32'(m_addr) : 32'd0);
                chk("m_wdata", wdata, e_sel ? m_wdata : 32'd0);
                chk("m_cmd_ready", 32'(cmd_ready), 32'(m_age < 0 && !m_pend));
                chk("m_rsp_valid", 32'(rsp_valid), 32'(m_pend));
                chk("m_rsp_rdata", rsp_rdata, m_pend ? m_rdata : 32'd0);
                chk("m_rsp_error", 32'(rsp_error), 32'(m_pend && m_err));
            end
        end
    endtask

    task automatic do_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d, output int acc);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("cmd_accepted", 32'(acc >= 0), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rc = cyc;
                break;
            end
        end
        chk("rsp_seen", 32'(rc >= 0), 32'd1);
    endtask

    initial begin
        int acc, rc, a0, s0, zc, hs;
        logic [31:0] snap;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // 1: zero-wait read
        ready_after = 0; rdata = 32'h0001_0203;
        do_cmd(1'b0, 8'h00, 32'h0, acc);
        wait_rsp(rc);
        chk("t1_latency", 32'(rc - acc), 32'd3);
        chk("t1_rdata", rsp_rdata, 32'h0001_0203);
        chk("t1_error", 32'(rsp_error), 32'd0);
        @(posedge clk); #1;

        // 2: write with three wait cycles
        ready_after = 3; rdata = 32'h5555_AAAA; a0 = acc_total;
        do_cmd(1'b1, 8'h04, 32'hDEAD_BEEF, acc);
        wait_rsp(rc);
        chk("t2_access_cycles", 32'(acc_total - a0), 32'd4);
        chk("t2_error", 32'(rsp_error), 32'd0);
        chk("t2_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;

        // 3: rejected write address
        s0 = sel_total;
        do_cmd(1'b1, 8'h0C, 32'h1111_2222, acc);
        wait_rsp(rc);
        chk("t3_latency", 32'(rc - acc), 32'd1);
        chk("t3_no_sel", 32'(sel_total - s0), 32'd0);
        chk("t3_error", 32'(rsp_error), 32'd1);
        @(posedge clk); #1;

        // 4: timeout
        ready_after = -1; a0 = acc_total;
        do_cmd(1'b0, 8'h08, 32'h0, acc);
        wait_rsp(rc);
        chk("t4_access_cycles", 32'(acc_total - a0), 32'd16);
        chk("t4_error", 32'(rsp_error), 32'd1);
        chk("t4_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;

        // 5: response back-pressure with a second command waiting
        rsp_ready = 1'b0; ready_after = 0; rdata = 32'hCAFE_0001;
        do_cmd(1'b0, 8'h00, 32'h0, acc);
        wait_rsp(rc);
        cmd_write = 1'b1; cmd_addr = 8'h08; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
        snap = rsp_rdata; zc = 0;
        chk("t5_rdata", snap, 32'hCAFE_0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!cmd_ready && rsp_valid && rsp_rdata == snap) zc++;
        end
        chk("t5_held", 32'(zc), 32'd5);
        rsp_ready = 1'b1; hs = cyc;
        do_cmd(1'b1, 8'h08, 32'h1234_5678, acc);
        chk("t5_accept_after_hs", 32'(acc - hs), 32'd1);
        wait_rsp(rc);
        chk("t5_second_error", 32'(rsp_error), 32'd0);
        @(posedge clk); #1;

        // 6: reset during ACCESS
        ready_after = -1;
        do_cmd(1'b0, 8'h04, 32'h0, acc);
        zc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (enable) begin
                zc = 1;
                break;
            end
        end
        chk("t6_in_access", 32'(zc), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_sel_drop", 32'(sel), 32'd0);
        chk("t6_enable_drop", 32'(enable), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_idle_sel", 32'(sel), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
